sram_march_bist: RTL and testbench

- Built-in self-test sequencer for one OpenRAM macro on the test chip.
- Runs a March C- algorithm on port 0 of one SRAM selected from the 16-macro bank, and drives the shared port-0 control/data bus (addr0, din0, web0, wmask0, per-chip csb0).
- Compares read data returned through the per-chip data mux, and records first-failure diagnostics plus an error count.
- Sits alongside the wishbone and scan-chain control paths; upper-level muxing hands it the port-0 bus while busy.

---
 rtl/sram_march_bist_if.sv | 33 +++
 rtl/sram_march_bist.sv | 199 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_if.sv
// Port-0 bus between the March BIST sequencer and the OpenRAM bank.
// The master drives control, address and write data; the slave returns muxed read data.
interface sram_march_bist_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4,
    parameter int unsigned MAX_CHIPS   = 16
);
    logic [MAX_CHIPS-1:0]   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  sram_dout0;

    modport master (
        output csb0,
        output web0,
        output wmask0,
        output addr0,
        output din0,
        input  sram_dout0
    );

    modport slave (
        input  csb0,
        input  web0,
        input  wmask0,
        input  addr0,
        input  din0,
        output sram_dout0
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST sequencer for one OpenRAM macro on the shared port-0 bus.
// Records first-failure diagnostics and a saturating mismatch count.
module sram_march_bist #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WMASK_WIDTH  = 4,
    parameter int unsigned SELECT_WIDTH = 4,
    parameter int unsigned MAX_CHIPS    = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start,
    input  logic [SELECT_WIDTH-1:0] chip_sel,
    input  logic [DATA_WIDTH-1:0]   pattern,
    input  logic [ADDR_WIDTH-1:0]   addr_last,
    sram_march_bist_if.master       sram,
    output logic                    busy,
    output logic                    done,
    output logic                    fail,
    output logic [2:0]              fail_element,
    output logic [ADDR_WIDTH-1:0]   fail_addr,
    output logic [DATA_WIDTH-1:0]   fail_data,
    output logic [15:0]             err_count
);
    localparam int unsigned LAT       = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
    localparam int unsigned LAT_W     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [2:0]  LAST_ELEM = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    logic [2:0]              elem_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LAT_W-1:0]        wait_cnt;
    logic [SELECT_WIDTH-1:0] chip_sel_q;
    logic [DATA_WIDTH-1:0]   pattern_q;
    logic [ADDR_WIDTH-1:0]   addr_last_q;

    logic                    dir_up;
    logic                    at_end;
    logic                    last_op;
    logic [2:0]              nxt_elem;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   rd_exp;
    logic                    mismatch;
    logic                    wait_last;
    logic [MAX_CHIPS-1:0]    sel_csb;
    logic [MAX_CHIPS-1:0]    start_csb;

    // March position bookkeeping: next address/element and per-element data.
    // Elements 0..2 run upward, 3..5 downward; the counter stops at the end address.
    always_comb begin
        dir_up    = (elem_q < 3'd3);
        at_end    = dir_up ? (addr_q == addr_last_q) : (addr_q == '0);
        nxt_elem  = elem_q;
        nxt_addr  = dir_up ? (addr_q + ADDR_WIDTH'(1)) : (addr_q - ADDR_WIDTH'(1));
        if (at_end) begin
            nxt_elem = elem_q + 3'd1;
            nxt_addr = (elem_q >= 3'd2) ? addr_last_q : '0;
        end
        last_op   = at_end && (elem_q == LAST_ELEM);
        wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~pattern_q : pattern_q;
        rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pattern_q : pattern_q;
        mismatch  = (sram.sram_dout0 != rd_exp);
        wait_last = (wait_cnt == LAT_W'(LAT - 1));
        sel_csb   = ~(MAX_CHIPS'(1) << chip_sel_q);
        start_csb = ~(MAX_CHIPS'(1) << chip_sel);
    end

    // Sequencer with registered bus and status outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            elem_q       <= '0;
            addr_q       <= '0;
            wait_cnt     <= '0;
            chip_sel_q   <= '0;
            pattern_q    <= '0;
            addr_last_q  <= '0;
            sram.csb0    <= '1;
            sram.web0    <= 1'b1;
            sram.wmask0  <= '0;
            sram.addr0   <= '0;
            sram.din0    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_element <= '0;
            fail_addr    <= '0;
            fail_data    <= '0;
            err_count    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        chip_sel_q   <= chip_sel;
                        pattern_q    <= pattern;
                        addr_last_q  <= addr_last;
                        fail         <= 1'b0;
                        fail_element <= '0;
                        fail_addr    <= '0;
                        fail_data    <= '0;
                        err_count    <= '0;
                        elem_q       <= '0;
                        addr_q       <= '0;
                        busy         <= 1'b1;
                        sram.csb0    <= start_csb;
                        sram.web0    <= 1'b0;
                        sram.wmask0  <= '1;
                        sram.addr0   <= '0;
                        sram.din0    <= pattern;
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    // A write always closes its address step; move on and issue the next op.
                    elem_q     <= nxt_elem;
                    addr_q     <= nxt_addr;
                    sram.addr0 <= nxt_addr;
                    sram.csb0  <= sel_csb;
                    if (nxt_elem == 3'd0) begin
                        sram.web0   <= 1'b0;
                        sram.wmask0 <= '1;
                        sram.din0   <= pattern_q;
                        state       <= WRITE;
                    end else begin
                        sram.web0   <= 1'b1;
                        sram.wmask0 <= '0;
                        sram.din0   <= '0;
                        state       <= READ;
                    end
                end

                READ: begin
                    sram.csb0 <= '1;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end

                WAIT: begin
                    if (wait_last) begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                            if (!fail) begin
                                fail         <= 1'b1;
                                fail_element <= elem_q;
                                fail_addr    <= addr_q;
                                fail_data    <= sram.sram_dout0;
                            end
                        end
                        if (elem_q != LAST_ELEM) begin
                            sram.csb0   <= sel_csb;
                            sram.web0   <= 1'b0;
                            sram.wmask0 <= '1;
                            sram.addr0  <= addr_q;
                            sram.din0   <= wr_data;
                            state       <= WRITE;
                        end else if (last_op) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            elem_q      <= nxt_elem;
                            addr_q      <= nxt_addr;
                            sram.csb0   <= sel_csb;
                            sram.web0   <= 1'b1;
                            sram.wmask0 <= '0;
                            sram.addr0  <= nxt_addr;
                            sram.din0   <= '0;
                            state       <= READ;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: vector table of March runs on an SRAM model,
// plus hand-written sequences for latency 2, mid-run start and mid-run reset.
module tb_sram_march_bist;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned NC = 16;

    typedef struct {
        logic [SW-1:0] sel;
        logic [DW-1:0] pat;
        logic [AW-1:0] last;
        int            fault;
        int            exp_busy;
        int            exp_acc;
        logic          exp_fail;
        logic [2:0]    exp_elem;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        int            exp_err;
        logic [NC-1:0] exp_csb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start1;
    logic          start2;
    logic [SW-1:0] chip_sel;
    logic [DW-1:0] pattern;
    logic [AW-1:0] addr_last;

    logic          busy1, done1, fail1, busy2, done2, fail2;
    logic [2:0]    fe1, fe2;
    logic [AW-1:0] fa1, fa2;
    logic [DW-1:0] fd1, fd2;
    logic [15:0]   ec1, ec2;

    sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .MAX_CHIPS(NC)) bus1 ();
    sram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .MAX_CHIPS(NC)) bus2 ();

    sram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
        .SELECT_WIDTH(SW), .MAX_CHIPS(NC), .READ_LATENCY(1)
    ) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start1), .chip_sel(chip_sel),
        .pattern(pattern), .addr_last(addr_last), .sram(bus1),
        .busy(busy1), .done(done1), .fail(fail1), .fail_element(fe1),
        .fail_addr(fa1), .fail_data(fd1), .err_count(ec1)
    );

    sram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW),
        .SELECT_WIDTH(SW), .MAX_CHIPS(NC), .READ_LATENCY(2)
    ) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start2), .chip_sel(chip_sel),
        .pattern(pattern), .addr_last(addr_last), .sram(bus2),
        .busy(busy2), .done(done2), .fail(fail2), .fail_element(fe2),
        .fail_addr(fa2), .fail_data(fd2), .err_count(ec2)
    );

    // SRAM models: 0 = fault-free, 1 = addr 2 bit 0 stuck-at-0, 2 = reads always return 0.
    int            fault_mode;
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem2 [256];
    logic [DW-1:0] rd1, rd2a, rd2b;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m, input bit stuck0);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(MW); b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        if (stuck0) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus1.csb0 != '1) begin
            if (!bus1.web0)
                mem1[bus1.addr0] <= merge(mem1[bus1.addr0], bus1.din0, bus1.wmask0,
                                          (fault_mode == 1) && (bus1.addr0 == 8'd2));
            else
                rd1 <= mem1[bus1.addr0];
        end
        if (bus2.csb0 != '1) begin
            if (!bus2.web0) mem2[bus2.addr0] <= merge(mem2[bus2.addr0], bus2.din0, bus2.wmask0, 1'b0);
            else            rd2a <= mem2[bus2.addr0];
        end
        rd2b <= rd2a;
    end

    assign bus1.sram_dout0 = (fault_mode == 2) ? '0 : rd1;
    assign bus2.sram_dout0 = rd2b;

    // Bus monitors, sampled on the falling edge; counters restart whenever run_id changes.
    int            run_id = 0;
    int            mon_run1 = 0, mon_run2 = 0;
    logic [NC-1:0] exp_csb;
    int            busy_cnt, done_cnt, acc_cnt, viol_cnt;
    logic          last_web;
    logic [AW-1:0] last_addr, max_addr;
    int            busy2_cnt, done2_cnt, acc2_cnt, wr2_cnt;
    logic [AW-1:0] max_addr2;
    logic [DW-1:0] wr2_first, wr2_second;

    always @(negedge clk) begin
        if (mon_run1 != run_id) begin
            mon_run1 = run_id;
            busy_cnt = 0; done_cnt = 0; acc_cnt = 0; viol_cnt = 0;
            last_web = 1'b0; last_addr = '1; max_addr = '0;
        end
        if (busy1) busy_cnt++;
        if (done1) done_cnt++;
        if (bus1.csb0 != '1) begin
            acc_cnt++;
            last_web  = bus1.web0;
            last_addr = bus1.addr0;
            if (bus1.addr0 > max_addr) max_addr = bus1.addr0;
            if (bus1.csb0 != exp_csb) viol_cnt++;
            if (!bus1.web0 && bus1.wmask0 != '1) viol_cnt++;
            if (bus1.web0 && (bus1.wmask0 != '0 || bus1.din0 != '0)) viol_cnt++;
        end else if (!bus1.web0) begin
            viol_cnt++;
        end
    end

    always @(negedge clk) begin
        if (mon_run2 != run_id) begin
            mon_run2 = run_id;
            busy2_cnt = 0; done2_cnt = 0; acc2_cnt = 0; wr2_cnt = 0;
            max_addr2 = '0; wr2_first = '0; wr2_second = '0;
        end
        if (busy2) busy2_cnt++;
        if (done2) done2_cnt++;
        if (bus2.csb0 != '1) begin
            acc2_cnt++;
            if (bus2.addr0 > max_addr2) max_addr2 = bus2.addr0;
            if (!bus2.web0) begin
                if (wr2_cnt == 0) wr2_first = bus2.din0;
                if (wr2_cnt == 1) wr2_second = bus2.din0;
                wr2_cnt++;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input int idx, input vec_t v, input int mid_start_at);
        bit got;
        chip_sel   = v.sel;
        pattern    = v.pat;
        addr_last  = v.last;
        fault_mode = v.fault;
        exp_csb    = v.exp_csb;
        run_id++;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            start1 = (c == mid_start_at);
            step();
            if (done1) begin
                got = 1'b1;
                break;
            end
        end
        start1 = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), 64'(got), 64'(1));
        step();
        step();
        chk($sformatf("v%0d_busy_cycles", idx), 64'(busy_cnt), 64'(v.exp_busy));
        chk($sformatf("v%0d_done_pulses", idx), 64'(done_cnt), 64'(1));
        chk($sformatf("v%0d_accesses", idx), 64'(acc_cnt), 64'(v.exp_acc));
        chk($sformatf("v%0d_bus_violations", idx), 64'(viol_cnt), 64'(0));
        chk($sformatf("v%0d_max_addr", idx), 64'(max_addr), 64'(v.last));
        chk($sformatf("v%0d_last_is_read", idx), 64'(last_web), 64'(1));
        chk($sformatf("v%0d_last_addr", idx), 64'(last_addr), 64'(0));
        chk($sformatf("v%0d_fail", idx), 64'(fail1), 64'(v.exp_fail));
        chk($sformatf("v%0d_fail_element", idx), 64'(fe1), 64'(v.exp_elem));
        chk($sformatf("v%0d_fail_addr", idx), 64'(fa1), 64'(v.exp_addr));
        chk($sformatf("v%0d_fail_data", idx), 64'(fd1), 64'(v.exp_data));
        chk($sformatf("v%0d_err_count", idx), 64'(ec1), 64'(v.exp_err));
        chk($sformatf("v%0d_idle_busy", idx), 64'(busy1), 64'(0));
        chk($sformatf("v%0d_idle_csb", idx), 64'(bus1.csb0), 64'(16'hFFFF));
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{4'd0,  32'h0,        8'd3,   0, 60,   40,   1'b0, 3'd0, 8'd0, 32'h0,        0,   16'hFFFE};
        vecs[1] = '{4'd0,  32'h0,        8'd3,   1, 60,   40,   1'b1, 3'd2, 8'd2, 32'hFFFFFFFE, 2,   16'hFFFE};
        vecs[2] = '{4'd5,  32'h0,        8'd3,   0, 60,   40,   1'b0, 3'd0, 8'd0, 32'h0,        0,   16'hFFDF};
        vecs[3] = '{4'd15, 32'h12345678, 8'd7,   0, 120,  80,   1'b0, 3'd0, 8'd0, 32'h0,        0,   16'h7FFF};
        vecs[4] = '{4'd3,  32'hFFFFFFFF, 8'd255, 2, 3840, 2560, 1'b1, 3'd1, 8'd0, 32'h0,        768, 16'hFFF7};
        vecs[5] = '{4'd9,  32'h0F0F0F0F, 8'd0,   1, 15,   10,   1'b0, 3'd0, 8'd0, 32'h0,        0,   16'hFDFF};

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        chip_sel = '0; pattern = '0; addr_last = '0; fault_mode = 0; exp_csb = 16'hFFFE;
        repeat (3) step();
        chk("rst_csb0", 64'(bus1.csb0), 64'(16'hFFFF));
        chk("rst_web0", 64'(bus1.web0), 64'(1));
        chk("rst_wmask0", 64'(bus1.wmask0), 64'(0));
        chk("rst_addr0", 64'(bus1.addr0), 64'(0));
        chk("rst_din0", 64'(bus1.din0), 64'(0));
        chk("rst_busy", 64'(busy1), 64'(0));
        chk("rst_done", 64'(done1), 64'(0));
        chk("rst_fail", 64'(fail1), 64'(0));
        chk("rst_err_count", 64'(ec1), 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run1(i, vecs[i], -1);
        end

        // Extra start pulse in the middle of a run must not disturb it.
        run1(10, vecs[0], 20);

        // Latency 2, single address.
        chip_sel = 4'd0; pattern = 32'hA5A5A5A5; addr_last = 8'd0;
        run_id++;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        begin
            bit got2;
            got2 = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                step();
                if (done2) begin
                    got2 = 1'b1;
                    break;
                end
            end
            chk("l2_done_seen", 64'(got2), 64'(1));
        end
        step();
        step();
        chk("l2_busy_cycles", 64'(busy2_cnt), 64'(20));
        chk("l2_done_pulses", 64'(done2_cnt), 64'(1));
        chk("l2_accesses", 64'(acc2_cnt), 64'(10));
        chk("l2_max_addr", 64'(max_addr2), 64'(0));
        chk("l2_writes", 64'(wr2_cnt), 64'(5));
        chk("l2_first_din", 64'(wr2_first), 64'(32'hA5A5A5A5));
        chk("l2_m1_din", 64'(wr2_second), 64'(32'h5A5A5A5A));
        chk("l2_fail", 64'(fail2), 64'(0));
        chk("l2_err_count", 64'(ec2), 64'(0));

        // Reset in the middle of M3 after one M2 mismatch has been counted.
        chip_sel = 4'd0; pattern = '0; addr_last = 8'd3; fault_mode = 1; exp_csb = 16'hFFFE;
        run_id++;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (31) step();
        chk("m3_busy_before_rst", 64'(busy1), 64'(1));
        chk("m3_err_before_rst", 64'(ec1), 64'(1));
        rst = 1'b1;
        step();
        chk("m3_rst_busy", 64'(busy1), 64'(0));
        chk("m3_rst_csb0", 64'(bus1.csb0), 64'(16'hFFFF));
        chk("m3_rst_web0", 64'(bus1.web0), 64'(1));
        chk("m3_rst_err_count", 64'(ec1), 64'(0));
        chk("m3_rst_fail", 64'(fail1), 64'(0));
        rst = 1'b0;
        step();
        step();
        chk("m3_post_rst_csb0", 64'(bus1.csb0), 64'(16'hFFFF));
        chk("m3_post_rst_busy", 64'(busy1), 64'(0));
        run1(11, vecs[0], -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
